// File: rtl/program_counter_if.sv
// Bus-side signals of the SAP-1 program counter: sequencer controls (Cp, Ep)
// and the shared tri-state W bus.
interface program_counter_if #(
  parameter int WIDTH = 4
);
  logic             Cp;
  logic             Ep;
  wire [WIDTH-1:0]  W_bus;

  // Sequencer side: issues count/enable, observes the bus
  modport master (
    output Cp,
    output Ep,
    input  W_bus
  );

  // Program counter side: receives controls, drives the bus when enabled
  modport slave (
    input  Cp,
    input  Ep,
    output W_bus
  );
endinterface

// File: rtl/program_counter.sv
// SAP-1 program counter: a WIDTH-bit up counter that drives the shared W bus
// only while Ep is high and releases it to high impedance otherwise.
module program_counter #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  program_counter_if.slave   bus
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_next_s;

  // Next count: clear beats count, count wraps modulo 2^WIDTH, otherwise hold
  always_comb begin
    cnt_next_s = cnt_r;
    if (CLR) begin
      cnt_next_s = {WIDTH{1'b0}};
    end else if (bus.Cp) begin
      cnt_next_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter register; CLR is applied through the next-state logic, so it is synchronous
  always_ff @(posedge CLK) begin
    cnt_r <= cnt_next_s;
  end

  // The bus must follow Ep with no clock delay, so the enable is purely combinational
  assign bus.W_bus = bus.Ep ? cnt_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: reset, counting, hold,
// wrap, clear priority, sequencer pattern and combinational bus enable.
module tb_program_counter;

  localparam int WIDTH = 4;

  logic CLK;
  logic CLR;
  int   vectors;
  int   miscompares;
  logic [WIDTH-1:0] exp_v;
  logic [WIDTH-1:0] z_v;

  program_counter_if #(.WIDTH(WIDTH)) intf ();

  program_counter #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (intf.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] expected);
    vectors++;
    assert (intf.W_bus === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, intf.W_bus, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    z_v         = 4'bzzzz;

    // Reset held for 5 edges with the bus enabled
    CLR     = 1'b1;
    intf.Cp = 1'b0;
    intf.Ep = 1'b1;
    tick(5);
    chk("reset_ep1", 4'h0);
    intf.Ep = 1'b0;
    #1;
    chk("reset_ep0", z_v);

    // Count three edges, then hold for four
    CLR     = 1'b0;
    intf.Ep = 1'b1;
    intf.Cp = 1'b1;
    tick(1); chk("count1", 4'h1);
    tick(1); chk("count2", 4'h2);
    tick(1); chk("count3", 4'h3);
    intf.Cp = 1'b0;
    tick(4); chk("hold3", 4'h3);

    // Ep toggled between edges: bus follows immediately, count untouched
    intf.Ep = 1'b0;
    #1; chk("ep_off_mid", z_v);
    intf.Ep = 1'b1;
    #1; chk("ep_on_mid", 4'h3);

    // Wrap from 15 to 0
    intf.Cp = 1'b1;
    tick(12); chk("preload15", 4'hF);
    tick(1);  chk("wrap0", 4'h0);

    // Clear overrides count on the same edge
    tick(7);  chk("preload7", 4'h7);
    CLR = 1'b1;
    tick(1);  chk("clr_over_cp", 4'h0);
    CLR     = 1'b0;
    intf.Cp = 1'b0;
    tick(1);  chk("after_clr_hold", 4'h0);
    intf.Cp = 1'b1;
    tick(1);  chk("resume1", 4'h1);
    CLR = 1'b1;
    tick(1);  chk("reclear", 4'h0);
    CLR     = 1'b0;
    intf.Cp = 1'b0;

    // Sequencer pattern: read 3, count 6 with bus released, idle 9
    exp_v = 4'h0;
    for (int r = 0; r < 4; r++) begin
      intf.Ep = 1'b1;
      intf.Cp = 1'b0;
      #1; chk($sformatf("seq%0d_read_pre", r), exp_v);
      for (int k = 0; k < 3; k++) begin
        tick(1); chk($sformatf("seq%0d_read%0d", r, k), exp_v);
      end
      intf.Ep = 1'b0;
      intf.Cp = 1'b1;
      for (int k = 0; k < 6; k++) begin
        tick(1); chk($sformatf("seq%0d_cnt%0d", r, k), z_v);
      end
      intf.Cp = 1'b0;
      for (int k = 0; k < 9; k++) begin
        tick(1); chk($sformatf("seq%0d_idle%0d", r, k), z_v);
      end
      exp_v = exp_v + 4'd6;
    end
    // After four rounds the count has advanced by 24 mod 16
    intf.Ep = 1'b1;
    #1; chk("seq_final", 4'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
